// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/fulladder.sv
// Gate-level single-bit full-adder cell.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic xy_x;

  assign xy_x = x ^ y;
  assign s    = xy_x ^ ci;
  assign co   = (x & y) | (ci & xy_x);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Result is valid on the single-cycle done pulse and holds until the next accept.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = SA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  sa_state_e     state, state_nxt;
  logic [N-1:0]  op_a, op_b, sum_q, sum_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          load, shift_en;
  logic          fa_s, fa_co;

  fulladder u_fa (
    .x (op_a[0]),
    .y (op_b[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE accepts start exactly like IDLE, which gives back-to-back throughput.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_nxt        = sum_q >> 1;
    sum_nxt[N-1]   = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (shift_en) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      sum_q <= sum_nxt;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8) against a plain a+b+cin model.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [N-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a negedge, then wait for done; lat counts negedges after accept.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic,
                        output logic [N-1:0] rs, output logic rc,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cin = ic;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    rs = sum;
    rc = cout;
  endtask

  task automatic test_reset();
    logic [N-1:0] rs; logic rc; int lat, bc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0)    begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    @(negedge clk); rst = 1'b0;
    // Start an op and yank reset between E4 and E5.
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL async_rst_done got=%b exp=0", done); end
    checks++; if (sum !== '0)    begin failures++; $display("FAIL async_rst_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL async_rst_cout got=%b exp=0", cout); end
    @(negedge clk); rst = 1'b0;
    run_op(8'h03, 8'h04, 1'b0, rs, rc, lat, bc);
    checks++;
    if ({rc, rs} !== 9'h007) begin failures++; $display("FAIL post_rst_op got=%b_%h exp=0_07", rc, rs); end
  endtask

  task automatic test_full_ripple();
    logic [N-1:0] rs; logic rc; int lat, bc;
    run_op(8'hFF, 8'h01, 1'b0, rs, rc, lat, bc);
    checks++; if (lat != N + 1) begin failures++; $display("FAIL ripple_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if (bc != N)      begin failures++; $display("FAIL ripple_busy_cycles got=%0d exp=%0d", bc, N); end
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL ripple_sum got=%h exp=00", rs); end
    checks++; if (rc !== 1'b1)  begin failures++; $display("FAIL ripple_cout got=%b exp=1", rc); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ripple_done_width got=%b exp=0", done); end
    checks++; if ({cout, sum} !== 9'h100) begin failures++; $display("FAIL ripple_hold got=%b_%h exp=1_00", cout, sum); end
  endtask

  task automatic test_carry_in();
    logic [N-1:0] rs; logic rc; int lat, bc;
    run_op(8'hA5, 8'h5A, 1'b1, rs, rc, lat, bc);
    checks++; if ({rc, rs} !== 9'h100) begin failures++; $display("FAIL cin_a5_5a got=%b_%h exp=1_00", rc, rs); end
    run_op(8'h3C, 8'h0F, 1'b1, rs, rc, lat, bc);
    checks++; if ({rc, rs} !== 9'h04C) begin failures++; $display("FAIL cin_3c_0f got=%b_%h exp=0_4c", rc, rs); end
  endtask

  task automatic test_start_ignored();
    int lat, extra;
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(negedge clk);               // after E0
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin start = 1'b1; a = 8'h11; b = 8'h22; end  // sampled at E3
      else start = 1'b0;
    end
    start = 1'b0;
    checks++; if (lat != N + 1) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if ({cout, sum} !== 9'h002) begin failures++; $display("FAIL ignore_sum got=%b_%h exp=0_02", cout, sum); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_no_second got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);
    a = 8'h80; b = 8'h80;         // start stays high, ignored during SHIFT
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != N + 1) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if ({cout, sum} !== 9'h046) begin failures++; $display("FAIL b2b_first_sum got=%b_%h exp=0_46", cout, sum); end
    @(negedge clk);               // after EN+1, the second accept
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_done_width got=done%b busy%b exp=done0 busy1", done, busy); end
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != N + 1) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if ({cout, sum} !== 9'h100) begin failures++; $display("FAIL b2b_second_sum got=%b_%h exp=1_00", cout, sum); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb, rs; logic rcin, rc; int lat, bc;
    logic [N:0] exp;
    for (int i = 0; i < 200; i++) begin
      ra = N'($urandom); rb = N'($urandom); rcin = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rcin};
      run_op(ra, rb, rcin, rs, rc, lat, bc);
      checks++;
      if ({rc, rs} !== exp || lat != N + 1) begin
        failures++;
        $display("FAIL rand_%0d a=%h b=%h cin=%b got=%b_%h lat=%0d exp=%b_%h lat=%0d",
                 i, ra, rb, rcin, rc, rs, lat, exp[N], exp[N-1:0], N + 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL rand_done_width_%0d got=%b exp=0", i, done); end
    end
  endtask

  initial begin
    test_reset();
    test_full_ripple();
    test_carry_in();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
